// File: rtl/ob_fetch_if.sv
// Bus bundle between the object-processor fetch requesters, the memory port
// and ob_fetch_ctl. The controller drives the request/latch side (master).
interface ob_fetch_if #(
    parameter int AW = 21
);
    logic          list_req;
    logic [AW-1:0] list_addr;
    logic [3:0]    list_len;
    logic          data_req;
    logic [AW-1:0] data_addr;
    logic [3:0]    data_len;
    logic          abort;
    logic          mack;
    logic          mreq;
    logic [AW-1:0] maddr;
    logic          latch;
    logic          ltag;
    logic [3:0]    lidx;
    logic          list_done;
    logic          data_done;
    logic          busy;

    modport master (
        input  list_req, list_addr, list_len,
        input  data_req, data_addr, data_len,
        input  abort, mack,
        output mreq, maddr, latch, ltag, lidx,
        output list_done, data_done, busy
    );

    modport slave (
        output list_req, list_addr, list_len,
        output data_req, data_addr, data_len,
        output abort, mack,
        input  mreq, maddr, latch, ltag, lidx,
        input  list_done, data_done, busy
    );
endinterface

// File: rtl/ob_fetch_ctl.sv
// Phrase-fetch sequencer: arbitrates list/data requesters and runs 1-16 phrase bursts.
// Define OB_FETCH_RR_EN for round-robin arbitration (default: list has fixed priority).
module ob_fetch_ctl #(
    parameter int AW = 21
) (
    input  logic         clk,
    input  logic         resetl,
    ob_fetch_if.master   bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_addr;
    logic [3:0]    r_len;
    logic [3:0]    r_cnt;
    logic          r_tag;
    logic          w_gnt;
    logic          w_gnt_tag;

`ifdef OB_FETCH_RR_EN
    // Tag of the most recent grant; resets to data so list wins the first tie.
    logic          r_last;

    always_comb begin
        w_gnt = ~bus.abort & (bus.list_req | bus.data_req);
        if (bus.list_req && bus.data_req)
            w_gnt_tag = ~r_last;
        else
            w_gnt_tag = ~bus.list_req;
    end
`else
    always_comb begin
        w_gnt     = ~bus.abort & (bus.list_req | bus.data_req);
        w_gnt_tag = ~bus.list_req;
    end
`endif

    always_ff @(posedge clk) begin
        if (!resetl)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        bus.mreq      = 1'b0;
        bus.latch     = 1'b0;
        bus.ltag      = 1'b0;
        bus.lidx      = 4'd0;
        bus.list_done = 1'b0;
        bus.data_done = 1'b0;
        bus.busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_gnt)
                    w_next = S_BUSY;
            end
            S_BUSY: begin
                bus.mreq = 1'b1;
                bus.busy = 1'b1;
                if (bus.mack) begin
                    bus.latch = 1'b1;
                    bus.ltag  = r_tag;
                    bus.lidx  = r_cnt;
                end
                // Abort wins over a coincident final ack: no done pulse.
                if (bus.abort)
                    w_next = S_IDLE;
                else if (bus.mack && (r_cnt == r_len))
                    w_next = S_DONE;
            end
            S_DONE: begin
                bus.busy      = 1'b1;
                bus.list_done = ~r_tag;
                bus.data_done = r_tag;
                w_next        = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign bus.maddr = r_addr;

    always_ff @(posedge clk) begin
        if (!resetl) begin
            r_addr <= '0;
            r_len  <= 4'd0;
            r_cnt  <= 4'd0;
            r_tag  <= 1'b0;
`ifdef OB_FETCH_RR_EN
            r_last <= 1'b1;
`endif
        end else if (r_state == S_IDLE && w_gnt) begin
            r_addr <= w_gnt_tag ? bus.data_addr : bus.list_addr;
            r_len  <= w_gnt_tag ? bus.data_len  : bus.list_len;
            r_tag  <= w_gnt_tag;
            r_cnt  <= 4'd0;
`ifdef OB_FETCH_RR_EN
            r_last <= w_gnt_tag;
`endif
        end else if (r_state == S_BUSY && bus.mack) begin
            r_addr <= r_addr + AW'(1);
            r_cnt  <= r_cnt + 4'd1;
        end
    end
endmodule

// File: tb/tb_ob_fetch_ctl.sv
// Directed testbench for ob_fetch_ctl; expectations are hand-computed per vector.
// Honours OB_FETCH_RR_EN for the simultaneous-request sequence.
module tb_ob_fetch_ctl;
    localparam int AW = 21;

    logic clk;
    logic resetl;
    int   n_tests;
    int   n_fail;

    ob_fetch_if #(.AW(AW)) u_if ();

    ob_fetch_ctl #(.AW(AW)) dut (
        .clk    (clk),
        .resetl (resetl),
        .bus    (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here, checks follow #1 later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".mreq"},  32'(u_if.mreq), 0);
        chk({tag, ".latch"}, 32'(u_if.latch), 0);
        chk({tag, ".ltag"},  32'(u_if.ltag), 0);
        chk({tag, ".lidx"},  32'(u_if.lidx), 0);
        chk({tag, ".ldone"}, 32'(u_if.list_done), 0);
        chk({tag, ".ddone"}, 32'(u_if.data_done), 0);
        chk({tag, ".busy"},  32'(u_if.busy), 0);
    endtask

    logic [AW-1:0] wrap_exp [4];
    logic          tie_exp  [4];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        resetl  = 1'b0;
        u_if.list_req  = 1'b0;
        u_if.list_addr = '0;
        u_if.list_len  = 4'd0;
        u_if.data_req  = 1'b0;
        u_if.data_addr = '0;
        u_if.data_len  = 4'd0;
        u_if.abort     = 1'b0;
        u_if.mack      = 1'b0;
        cyc();
        cyc();
        #1;
        chk_quiet("reset");
        chk("reset.maddr", 32'(u_if.maddr), 0);
        resetl = 1'b1;
        cyc();

        // Single list burst, len 3, ack every cycle
        u_if.list_req  = 1'b1;
        u_if.list_addr = 21'h00100;
        u_if.list_len  = 4'd3;
        u_if.mack      = 1'b1;
        #1;
        chk("l1.idle_latch", 32'(u_if.latch), 0);
        chk("l1.idle_mreq",  32'(u_if.mreq), 0);
        cyc();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("l1.mreq",  32'(u_if.mreq), 1);
            chk("l1.maddr", 32'(u_if.maddr), 32'h100 + 32'(i));
            chk("l1.latch", 32'(u_if.latch), 1);
            chk("l1.lidx",  32'(u_if.lidx), 32'(i));
            chk("l1.ltag",  32'(u_if.ltag), 0);
            chk("l1.ldone", 32'(u_if.list_done), 0);
            cyc();
        end
        #1;
        chk("l1.done_mreq",  32'(u_if.mreq), 0);
        chk("l1.done_pulse", 32'(u_if.list_done), 1);
        chk("l1.done_dd",    32'(u_if.data_done), 0);
        chk("l1.done_latch", 32'(u_if.latch), 0);
        chk("l1.done_busy",  32'(u_if.busy), 1);
        u_if.list_req = 1'b0;
        u_if.mack     = 1'b0;
        cyc();
        #1;
        chk_quiet("l1.idle");

        // Stalled acks on a data burst, len 1, mack 0,1,0,0,1
        u_if.data_req  = 1'b1;
        u_if.data_addr = 21'h002A0;
        u_if.data_len  = 4'd1;
        cyc();
        u_if.mack = 1'b0;
        #1;
        chk("st.c0_maddr", 32'(u_if.maddr), 32'h2A0);
        chk("st.c0_latch", 32'(u_if.latch), 0);
        chk("st.c0_mreq",  32'(u_if.mreq), 1);
        cyc();
        u_if.mack = 1'b1;
        #1;
        chk("st.c1_maddr", 32'(u_if.maddr), 32'h2A0);
        chk("st.c1_latch", 32'(u_if.latch), 1);
        chk("st.c1_lidx",  32'(u_if.lidx), 0);
        chk("st.c1_ltag",  32'(u_if.ltag), 1);
        for (int i = 2; i < 4; i++) begin
            cyc();
            u_if.mack = 1'b0;
            #1;
            chk("st.wait_maddr", 32'(u_if.maddr), 32'h2A1);
            chk("st.wait_latch", 32'(u_if.latch), 0);
            chk("st.wait_done",  32'(u_if.data_done), 0);
        end
        cyc();
        u_if.mack = 1'b1;
        #1;
        chk("st.c4_maddr", 32'(u_if.maddr), 32'h2A1);
        chk("st.c4_latch", 32'(u_if.latch), 1);
        chk("st.c4_lidx",  32'(u_if.lidx), 1);
        chk("st.c4_ltag",  32'(u_if.ltag), 1);
        cyc();
        u_if.mack = 1'b0;
        #1;
        chk("st.ddone", 32'(u_if.data_done), 1);
        chk("st.ldone", 32'(u_if.list_done), 0);
        chk("st.mreq",  32'(u_if.mreq), 0);
        u_if.data_req = 1'b0;
        cyc();

        // Simultaneous requests, len 0, both re-raised in every IDLE cycle
`ifdef OB_FETCH_RR_EN
        tie_exp = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        tie_exp = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        u_if.list_addr = 21'h00010;
        u_if.list_len  = 4'd0;
        u_if.data_addr = 21'h00020;
        u_if.data_len  = 4'd0;
        for (int k = 0; k < 4; k++) begin
            u_if.list_req = 1'b1;
            u_if.data_req = 1'b1;
            u_if.mack     = 1'b1;
            #1;
            chk("tie.idle_busy", 32'(u_if.busy), 0);
            cyc();
            #1;
            chk("tie.ltag",  32'(u_if.ltag), 32'(tie_exp[k]));
            chk("tie.maddr", 32'(u_if.maddr), tie_exp[k] ? 32'h20 : 32'h10);
            chk("tie.lidx",  32'(u_if.lidx), 0);
            cyc();
            #1;
            chk("tie.ldone", 32'(u_if.list_done), 32'(!tie_exp[k]));
            chk("tie.ddone", 32'(u_if.data_done), 32'(tie_exp[k]));
            if (tie_exp[k]) u_if.data_req = 1'b0;
            else            u_if.list_req = 1'b0;
            cyc();
        end
        // Lone data request after the ties
        u_if.list_req = 1'b0;
        u_if.data_req = 1'b1;
        cyc();
        #1;
        chk("lone.ltag",  32'(u_if.ltag), 1);
        chk("lone.maddr", 32'(u_if.maddr), 32'h20);
        cyc();
        #1;
        chk("lone.ddone", 32'(u_if.data_done), 1);
        u_if.data_req = 1'b0;
        u_if.mack     = 1'b0;
        cyc();

        // Abort together with the third ack of a len-7 list burst
        u_if.list_req  = 1'b1;
        u_if.list_addr = 21'h00300;
        u_if.list_len  = 4'd7;
        u_if.mack      = 1'b1;
        cyc();
        cyc();
        cyc();
        u_if.abort    = 1'b1;
        u_if.list_req = 1'b0;
        #1;
        chk("ab.latch", 32'(u_if.latch), 1);
        chk("ab.lidx",  32'(u_if.lidx), 2);
        chk("ab.maddr", 32'(u_if.maddr), 32'h302);
        cyc();
        u_if.abort = 1'b0;
        #1;
        chk_quiet("ab.after");
        // Abort in IDLE blocks the grant for that cycle
        u_if.data_req  = 1'b1;
        u_if.data_addr = 21'h00400;
        u_if.data_len  = 4'd0;
        u_if.abort     = 1'b1;
        cyc();
        u_if.abort = 1'b0;
        #1;
        chk("ab.idle_block", 32'(u_if.mreq), 0);
        cyc();
        #1;
        chk("ab.new_mreq",  32'(u_if.mreq), 1);
        chk("ab.new_maddr", 32'(u_if.maddr), 32'h400);
        chk("ab.new_ltag",  32'(u_if.ltag), 1);
        cyc();
        u_if.abort    = 1'b1;
        u_if.data_req = 1'b0;
        #1;
        chk("ab.done_abort", 32'(u_if.data_done), 1);
        cyc();
        u_if.abort = 1'b0;
        u_if.mack  = 1'b0;

        // Address wrap-around
        wrap_exp = '{21'h1FFFFE, 21'h1FFFFF, 21'h000000, 21'h000001};
        u_if.list_req  = 1'b1;
        u_if.list_addr = 21'h1FFFFE;
        u_if.list_len  = 4'd3;
        u_if.mack      = 1'b1;
        cyc();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("wrap.maddr", 32'(u_if.maddr), 32'(wrap_exp[i]));
            cyc();
        end
        #1;
        chk("wrap.ldone", 32'(u_if.list_done), 1);
        u_if.list_req = 1'b0;
        cyc();

        // Reset in the middle of a burst
        u_if.data_req  = 1'b1;
        u_if.data_addr = 21'h00500;
        u_if.data_len  = 4'd15;
        u_if.mack      = 1'b1;
        cyc();
        cyc();
        #1;
        chk("rst.pre_maddr", 32'(u_if.maddr), 32'h501);
        resetl        = 1'b0;
        u_if.data_req = 1'b0;
        cyc();
        #1;
        chk_quiet("rst.mid");
        chk("rst.maddr", 32'(u_if.maddr), 0);
        resetl = 1'b1;
        cyc();
        #1;
        chk("rst.ign_latch", 32'(u_if.latch), 0);
        chk("rst.ign_mreq",  32'(u_if.mreq), 0);
        chk("rst.ign_maddr", 32'(u_if.maddr), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ob_fetch_ctl.md
# ob_fetch_ctl

Phrase-fetch sequencer for the object processor memory port. It arbitrates between the object-list fetcher and the bitmap-data fetcher, and runs a granted burst of 1–16 phrase reads on the bus: request, address increment, ack counting. For every accepted ack it emits a one-cycle latch strobe with a destination tag and phrase index, and pulses a per-requester done at burst end.

## Interface

Parameters:
- AW, 21, phrase address width (byte address bits 23:3).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- resetl  in  1  reset; synchronous, active-low.
- list_req  in  1  object-list burst request; held until list_done.
- list_addr  in  AW  list burst start phrase address; sampled at grant.
- list_len  in  4  list burst length minus 1 (0 = 1 phrase, 15 = 16 phrases); sampled at grant.
- data_req  in  1  bitmap-data burst request; held until data_done.
- data_addr  in  AW  data burst start phrase address; sampled at grant.
- data_len  in  4  data burst length minus 1; sampled at grant.
- abort  in  1  terminate current burst (object processor restart).
- mack  in  1  bus ack; one phrase is transferred per cycle with mreq & mack.
- mreq  out  1  bus read request.
- maddr  out  AW  current phrase address.
- latch  out  1  phrase-latch strobe, equal to busy_state & mack.
- ltag  out  1  latch destination: 0 = list, 1 = data.
- lidx  out  4  phrase index within burst for the current latch.
- list_done  out  1  one-cycle pulse when a list burst completes.
- data_done  out  1  one-cycle pulse when a data burst completes.
- busy  out  1  high in BUSY and DONE states.

## Operation

- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If abort = 0 and any req is high, grant per arbitration.
  - Load addr, len, tag and cnt = 0.
  - Go to BUSY.
- BUSY:
  - mreq = 1 and maddr = addr register.
  - On mack: latch = 1, ltag = tag, lidx = cnt. Next edge: addr += 1 (wraps modulo 2^AW), cnt += 1.
  - When mack arrives with cnt == len, go to DONE.
- DONE: mreq = 0; the done pulse matching tag is high for one cycle; next state IDLE. Requesters must drop req in this cycle. The controller ignores req while in DONE, so the same request is never granted twice.
- Arbitration: list has fixed priority over data. A granted burst always runs to completion; there is no preemption.
- Dropping req during BUSY is ignored; the burst still completes and still pulses done.
- abort in BUSY:
  - Next state IDLE, with no done pulse.
  - An mack in the abort cycle is still latched (latch = 1) and counted.
  - abort in DONE has no effect.
  - abort in IDLE blocks grant for that cycle.
- mack outside BUSY is ignored: latch stays 0 and no state changes.
- Reset: state IDLE. mreq, latch, ltag, lidx, list_done, data_done and busy are all 0. maddr, addr and cnt are 0.

## Timing

- Grant latency: req sampled high in IDLE gives mreq = 1 on the next cycle.
- latch is combinational from mack: same cycle, no added latency.
- maddr advances the cycle after each ack, so back-to-back acks stream consecutive addresses.
- Burst of N phrases with ack every cycle: mreq is high N cycles, then DONE for 1 cycle, then IDLE for 1 cycle. The minimum request-to-request spacing is N+2 cycles.
- Done pulse appears 1 cycle after the final ack.

## Configuration

- OB_FETCH_RR_EN defined:
  - Round-robin arbitration. On simultaneous requests, grant the requester not granted last.
  - A 1-bit last-grant register is reset to data, so list wins the first tie.
  - A lone request is always granted.
- Undefined: fixed priority list > data, with no last-grant register.

## Test plan

- Single list burst: list_req = 1, list_addr = 0x00100, list_len = 3, mack held 1.
  - mreq high for 4 cycles; maddr = 0x00100..0x00103.
  - latch ×4 with lidx 0..3 and ltag = 0.
  - list_done pulse 1 cycle after the last ack; mreq low in that cycle.
- Stalled acks: data burst, len = 1, mack pattern 0,1,0,0,1.
  - maddr holds until each ack; latch only on ack cycles; lidx 0 then 1.
  - data_done 1 cycle after the second ack.
- Simultaneous requests, list_len = data_len = 0:
  - Without macro: list granted first, data granted after DONE/IDLE.
  - With OB_FETCH_RR_EN: alternate grants over 4 bursts (list, data, list, data).
- Abort with coincident ack: len = 7, abort together with the 3rd mack.
  - latch = 1 with lidx = 2 in that cycle; next cycle IDLE, mreq = 0.
  - No done pulse; a new request is then granted normally.
- Wrap-around: addr = 0x1FFFFE, len = 3 → maddr sequence 0x1FFFFE, 0x1FFFFF, 0x000000, 0x000001.
- Reset mid-burst: resetl = 0 during BUSY → next edge all outputs 0, state IDLE. Ignored mack afterwards gives latch = 0.
